alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code and sub flag from the ALU control decoder, plus two XLEN operands from the ID/EX path.
- Produces a registered result and a zero flag through a valid/ready handshake.
- Logic and arithmetic ops take one cycle. Shifts use an iterative 1-bit-per-cycle shifter, so latency depends on the shift amount; this saves area in the SoC core.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_ctrl  input  3  000 sum, 001 slt, 010 and, 011 or, 100 xor, 101 sra, 110 sll, 111 srl.
- sub  input  1  for sum: 1 = a-b, 0 = a+b; ignored for other codes.
- is_unsigned  input  1  for slt: 1 = unsigned compare (sltu), 0 = signed; ignored otherwise.
- op_a  input  XLEN  operand A / shift source.
- op_b  input  XLEN  operand B; for shifts only op_b[SHW-1:0] used.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  XLEN  registered result.
- zero  output  1  registered, 1 iff result == 0.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, result=0, zero=0, busy=0, shift counter=0. An in-flight shift is discarded, with no output.
- FSM states are IDLE, SHIFT and HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and does not depend on in_valid.
- Accept occurs when in_valid && in_ready on a rising edge. Operands and controls are captured at accept and upstream may change afterwards.
- Non-shift op, or shift with shamt==0:
  - The result is computed and registered at the accept edge.
  - out_valid=1 from the next cycle; next state = HOLD (1-cycle latency).
- Shift op with shamt=n>=1:
  - At accept: acc=op_a, cnt=n, state=SHIFT, out_valid=0.
  - Each SHIFT cycle shifts acc by 1 (sll: fill 0; srl: fill 0; sra: fill acc[XLEN-1]) and decrements cnt.
  - On the edge where cnt goes 1->0: result=shifted acc, out_valid=1, state=HOLD.
  - out_valid is first seen n cycles after accept.
  - in_ready=0 throughout SHIFT.
- HOLD:
  - result and zero are held stable while out_valid && !out_ready.
  - On out_ready with no new accept: out_valid=0, state=IDLE, result retains its value.
  - On out_ready with a simultaneous accept: this gives back-to-back operation. A non-shift op keeps out_valid=1 with the new result next cycle. A shift with n>=1 gives out_valid=0 and state=SHIFT.
- Arithmetic (all XLEN bits):
  - sum wraps modulo 2^XLEN.
  - slt signed: lt = (a[msb]!=b[msb]) ? a[msb] : diff[msb], where diff = a-b.
  - sltu: lt = borrow out of a-b.
  - The slt result is {XLEN-1 zeros, lt}.
- zero is registered together with result and updates only when result updates.
- Boundary cases:
  - shamt=XLEN-1: 31 cycles.
  - Upper op_b bits are ignored (op_b=0x25 gives shamt 5).
  - sra of a negative value saturates to all-ones.
  - in_valid while busy is not accepted; upstream must hold it.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed by a combinational barrel shifter at accept, so all ops have 1-cycle latency. The SHIFT state is unreachable and busy is tied to 0.
- Undefined: iterative shifter as above.
- The handshake, results and zero must be bit-identical in both builds; only latency differs.

Test Plan:
- Reset mid-shift: sll a=1, b=20, assert rst after 5 cycles -> out_valid=0, result=0, in_ready=1 immediately; no result emitted afterwards.
- sum: sub=0, a=0xFFFFFFFF, b=1 -> result 0, zero=1, out_valid 1 cycle after accept. sub=1, a=5, b=7 -> 0xFFFFFFFE, zero=0.
- slt/sltu: a=0xFFFFFFFF, b=1, is_unsigned=0 -> 1. Same operands with is_unsigned=1 -> 0.
- Shifts:
  - sra a=0x80000000, b=31 -> 0xFFFFFFFF after 31 cycles, busy high for 31 cycles.
  - srl same operands -> 0x00000001.
  - sll a=3, b=0 -> 3 with 1-cycle latency.
- Backpressure and back-to-back:
  - xor 0xF0F0 ^ 0x0FF0 with out_ready=0 for 4 cycles -> 0xFF00 held stable and in_ready=0.
  - Then out_ready=1 with in_valid (and 0xC, 0xA) -> next cycle result 0x8, out_valid stays 1.
- With ALU_BARREL_SHIFT_EN: repeat the shift vectors -> identical results, each with 1-cycle latency, busy always 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready result handshake and registered result/zero.
// Shifts step 1 bit per cycle unless ALU_BARREL_SHIFT_EN selects a 1-cycle barrel shifter.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic            sub,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [2:0] OpSum = 3'b000;
  localparam logic [2:0] OpSlt = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSra = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpSrl = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic            accept;
  logic [XLEN:0]   diff;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] imm_res;

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign accept   = in_valid && in_ready;

  // One extra bit on the subtraction gives the unsigned borrow for sltu.
  assign diff        = {1'b0, op_a} - {1'b0, op_b};
  assign lt_unsigned = diff[XLEN];
  assign lt_signed   = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : diff[XLEN-1];
  assign shamt       = op_b[SHW-1:0];
  assign is_shift    = (alu_ctrl == OpSra) || (alu_ctrl == OpSll) || (alu_ctrl == OpSrl);

  always_comb begin
    imm_res = '0;
    case (alu_ctrl)
      OpSum:   imm_res = sub ? diff[XLEN-1:0] : (op_a + op_b);
      OpSlt:   imm_res = {{(XLEN-1){1'b0}}, (is_unsigned ? lt_unsigned : lt_signed)};
      OpAnd:   imm_res = op_a & op_b;
      OpOr:    imm_res = op_a | op_b;
      OpXor:   imm_res = op_a ^ op_b;
`ifdef ALU_BARREL_SHIFT_EN
      OpSra:   imm_res = $signed(op_a) >>> shamt;
      OpSll:   imm_res = op_a << shamt;
      OpSrl:   imm_res = op_a >> shamt;
`else
      // Only reached here with shamt == 0; nonzero amounts go through the iterative path.
      OpSra:   imm_res = op_a;
      OpSll:   imm_res = op_a;
      OpSrl:   imm_res = op_a;
`endif
      default: imm_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign busy = 1'b0;
`else
  logic            busy_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  cnt_q;
  logic [1:0]      dir_q;
  logic [XLEN-1:0] acc_shifted;

  assign busy = busy_q;

  // dir_q holds alu_ctrl[1:0] of the shift: 01 sra, 10 sll, 11 srl.
  always_comb begin
    acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    case (dir_q)
      2'b10:   acc_shifted = {acc_q[XLEN-2:0], 1'b0};
      2'b11:   acc_shifted = {1'b0, acc_q[XLEN-1:1]};
      default: acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      busy_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift && (shamt != '0)) begin
        acc_q       <= op_a;
        cnt_q       <= shamt;
        dir_q       <= alu_ctrl[1:0];
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
        state_q     <= StShift;
      end else
`endif
      begin
        result_q    <= imm_res;
        zero_q      <= (imm_res == '0);
        out_valid_q <= 1'b1;
        state_q     <= StHold;
      end
    end else if ((state_q == StHold) && out_ready) begin
      out_valid_q <= 1'b0;
      state_q     <= StIdle;
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state_q == StShift) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        result_q    <= acc_shifted;
        zero_q      <= (acc_shifted == '0);
        out_valid_q <= 1'b1;
        busy_q      <= 1'b0;
        state_q     <= StHold;
      end
    end
`endif
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a reference model pushes expected results at accept,
// a negedge monitor pops them on each output handshake. Latency and busy time are checked per op.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic        sub;
  logic        is_unsigned;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .sub         (sub),
    .is_unsigned (is_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] c, input logic s, input logic u,
                                        input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = 32'(b[4:0]);
    case (c)
      3'd0:    r = s ? (a - b) : (a + b);
      3'd1:    r = u ? 32'(a < b) : 32'($signed(a) < $signed(b));
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = $signed(a) >>> sh;
      3'd6:    r = a << sh;
      default: r = a >> sh;
    endcase
    return r;
  endfunction

  // Number of negedge samples after the accept edge until out_valid is seen.
  function automatic int exp_lat(input logic [2:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (c >= 3'd5 && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      n_out++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_result", result, e.res);
        check("out_zero", 32'(zero), 32'(e.z));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns on the negedge where out_valid is first seen.
  task automatic do_op(input string tag, input logic [2:0] c, input logic s, input logic u,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    int   bcnt;
    int   want;
    bit   got;
    alu_ctrl    = c;
    sub         = s;
    is_unsigned = u;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    e.res = model(c, s, u, a, b);
    e.z   = (e.res == 32'd0);
    sb_q.push_back(e);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    check({tag, "_accept"}, 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 3'($urandom);
    want = exp_lat(c, b);
    lat  = 0;
    bcnt = 0;
    got  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 1 && want > 1) check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(want));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(want - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_ctrl    = 3'd0;
    sub         = 1'b0;
    is_unsigned = 1'b0;
    op_a        = 32'd0;
    op_b        = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    rst = 1'b0;

    // Reset in the middle of a long shift; out_ready low so no result can escape first.
    next_cycle();
    out_ready = 1'b0;
    alu_ctrl  = 3'd6;
    op_a      = 32'd1;
    op_b      = 32'd20;
    in_valid  = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    next_cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    snap      = n_out;
    repeat (40) @(posedge clk);
    check("midrst_no_output", 32'(n_out - snap), 32'd0);

    next_cycle(); do_op("sum_wrap", 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    next_cycle(); do_op("sub_neg",  3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
    next_cycle(); do_op("slt",      3'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    next_cycle(); do_op("sltu",     3'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    next_cycle(); do_op("slt_pos",  3'd1, 1'b0, 1'b0, 32'd3, 32'h7FFF_FFFF);
    next_cycle(); do_op("or",       3'd3, 1'b0, 1'b0, 32'h1200_0034, 32'h0050_6000);
    next_cycle(); do_op("sra31",    3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd31);
    next_cycle(); do_op("srl31",    3'd7, 1'b0, 1'b0, 32'h8000_0000, 32'd31);
    next_cycle(); do_op("sll0",     3'd6, 1'b0, 1'b0, 32'd3, 32'd0);
    next_cycle(); do_op("srl_hib",  3'd7, 1'b0, 1'b0, 32'hF000_0000, 32'h25);
    next_cycle(); do_op("sra4",     3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4);
    next_cycle(); do_op("sll_out",  3'd6, 1'b0, 1'b0, 32'h8000_0001, 32'd1);

    // Backpressure, then release together with a new accept for back-to-back issue.
    next_cycle();
    out_ready = 1'b0;
    do_op("bp_xor", 3'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_result", result, 32'h0000_FF00);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    next_cycle();
    out_ready = 1'b1;
    do_op("b2b_and", 3'd2, 1'b0, 1'b0, 32'hC, 32'hA);

    next_cycle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
